// File: rtl/bram_display_pkg.sv
// Shared types and helpers for the palette-mapped BRAM framebuffer display.
package bram_display_pkg;

  // 30-bit YCrCb pixel word as consumed by the video DAC mux.
  typedef logic [29:0] pixel_t;

  localparam pixel_t BORDER_COLOR_DEFAULT = {10'd0, 10'd512, 10'd512};
  localparam pixel_t PAL_RESET_FG         = 30'h3FFFFFFF;

  // Displayed window size after pixel replication.
  typedef struct packed {
    logic [12:0] w;
    logic [11:0] h;
  } win_ext_t;

  // Side-band bits that travel alongside the BRAM access.
  typedef struct packed {
    logic hit;
    logic hsync;
    logic vsync;
    logic blank;
  } side_t;

  function automatic win_ext_t window_extents(input int img_w, input int img_h,
                                              input int scale_log2);
    win_ext_t e;
    e.w = 13'(img_w << scale_log2);
    e.h = 12'(img_h << scale_log2);
    return e;
  endfunction

endpackage

// File: rtl/bram_display_pal_if.sv
// External BRAM read port: registered address out, data back after a fixed latency.
interface bram_display_pal_if #(
  parameter int ADDR_W = 19,
  parameter int BPP    = 4
);
  logic [ADDR_W-1:0] bram_addr;
  logic [BPP-1:0]    bram_read_data;

  modport master (output bram_addr, input  bram_read_data);
  modport slave  (input  bram_addr, output bram_read_data);
endinterface

// File: rtl/bram_display_pal_pipe_delay.sv
// Fixed-depth shift register with synchronous active-low clear.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's value from before the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/bram_display_pal.sv
// Palette-mapped BRAM framebuffer display with integer zoom and matched sync delay.
module bram_display_pal
  import bram_display_pkg::*;
#(
  parameter int     XOFFSET      = 0,
  parameter int     YOFFSET      = 0,
  parameter int     IMG_W        = 640,
  parameter int     IMG_H        = 480,
  parameter int     BPP          = 4,
  parameter int     SCALE_LOG2   = 0,
  parameter int     RD_LATENCY   = 2,
  parameter int     ADDR_W       = 19,
  parameter pixel_t BORDER_COLOR = BORDER_COLOR_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [10:0]               hcount,
  input  logic [9:0]                vcount,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      blank_in,
  bram_display_pal_if.master        bram,
  input  logic                      pal_we,
  input  logic [BPP-1:0]            pal_waddr,
  input  pixel_t                    pal_wdata,
  output pixel_t                    br_pixel,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      blank_out,
  output logic                      in_window
);

  localparam win_ext_t        WIN    = window_extents(IMG_W, IMG_H, SCALE_LOG2);
  localparam logic [12:0]     WIN_W  = WIN.w;
  localparam logic [11:0]     WIN_H  = WIN.h;
  localparam logic [9:0]      Y_MASK = 10'((1 << SCALE_LOG2) - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
  localparam int              PAL_N  = 1 << BPP;

  // ---------------------------------------------------------------------------
  // Stage 0: window test and incremental address generation
  // ---------------------------------------------------------------------------
  logic [10:0]       x;
  logic [9:0]        y;
  logic              x_hit, y_hit, hit;
  logic              row_end, sub_last, frame_end;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] addr_q;
  side_t             side0, side_d;

  // Unsigned wrap puts coordinates left of / above the window far out of range.
  assign x         = hcount - 11'(XOFFSET);
  assign y         = vcount - 10'(YOFFSET);
  assign x_hit     = {2'b00, x} < WIN_W;
  assign y_hit     = {2'b00, y} < WIN_H;
  assign hit       = x_hit && y_hit;
  assign row_end   = hit && ({2'b00, x} == WIN_W - 13'd1);
  assign sub_last  = (y & Y_MASK) == Y_MASK;
  assign frame_end = {2'b00, y} == WIN_H - 12'd1;
  assign col       = ADDR_W'(x >> SCALE_LOG2);

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q   <= '0;
      row_base <= '0;
      side0    <= '0;
    end else begin
      addr_q <= hit ? row_base + col : '0;
      // Forcing row_base to 0 outside the window lets a mid-frame start recover.
      if (!y_hit || (row_end && sub_last && frame_end)) begin
        row_base <= '0;
      end else if (row_end && sub_last) begin
        row_base <= row_base + ROW_STEP;
      end
      side0 <= '{hit: hit, hsync: hsync_in, vsync: vsync_in, blank: blank_in};
    end
  end

  assign bram.bram_addr = addr_q;

  // ---------------------------------------------------------------------------
  // Side-band delay matching the BRAM read latency
  // ---------------------------------------------------------------------------
  pipe_delay #(
    .WIDTH ($bits(side_t)),
    .DEPTH (RD_LATENCY)
  ) u_side_delay (
    .clk   (clk),
    .rst_n (reset),
    .d     (side0),
    .q     (side_d)
  );

  // ---------------------------------------------------------------------------
  // Final stage: palette lookup and output registers
  // ---------------------------------------------------------------------------
  pixel_t palette [PAL_N];

  always_ff @(posedge clk) begin
    if (!reset) begin
      br_pixel  <= BORDER_COLOR;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      blank_out <= 1'b0;
      in_window <= 1'b0;
      // NOTE: the palette is a register array, not RAM, precisely so it can be
      // reloaded on reset; a BRAM-mapped array must never carry a reset.
      for (int i = 0; i < PAL_N; i++) begin
        palette[i] <= (i == 0) ? BORDER_COLOR_DEFAULT : PAL_RESET_FG;
      end
    end else begin
      br_pixel  <= side_d.hit ? palette[bram.bram_read_data] : BORDER_COLOR;
      hsync_out <= side_d.hsync;
      vsync_out <= side_d.vsync;
      blank_out <= side_d.blank;
      in_window <= side_d.hit;
      // The lookup above sees the pre-edge entry, so a same-cycle write reads old.
      if (pal_we) palette[pal_waddr] <= pal_wdata;
    end
  end

endmodule

// File: tb/tb_bram_display_pal.sv
// Scoreboard bench: three differently configured instances driven with directed vectors.
module tb_bram_display_pal;
  import bram_display_pkg::*;

  localparam int     ND     = 3;
  localparam pixel_t BORDER = {10'd0, 10'd512, 10'd512};
  localparam pixel_t FG     = 30'h3FFFFFFF;

  // Instance 0: XOFFSET=10 YOFFSET=5 RD_LATENCY=2
  // Instance 1: SCALE_LOG2=1 320x240 RD_LATENCY=1
  // Instance 2: XOFFSET=800 RD_LATENCY=3
  function automatic int lat(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rst_n     [ND];
  logic [10:0]  hc        [ND];
  logic [9:0]   vc        [ND];
  logic         hs_i      [ND];
  logic         vs_i      [ND];
  logic         bl_i      [ND];
  logic         pal_we    [ND];
  logic [3:0]   pal_waddr [ND];
  pixel_t       pal_wdata [ND];
  pixel_t       pix_o     [ND];
  logic         win_o     [ND];
  logic         hs_o      [ND];
  logic         vs_o      [ND];
  logic         bl_o      [ND];
  logic [18:0]  addr_o    [ND];

  bram_display_pal_if #(.ADDR_W(19), .BPP(4)) bus0 ();
  bram_display_pal_if #(.ADDR_W(19), .BPP(4)) bus1 ();
  bram_display_pal_if #(.ADDR_W(19), .BPP(4)) bus2 ();

  assign addr_o[0] = bus0.bram_addr;
  assign addr_o[1] = bus1.bram_addr;
  assign addr_o[2] = bus2.bram_addr;

  // BRAM models returning addr[3:0] after the configured latency.
  logic [3:0] m0_d1 = '0, m0_d2 = '0;
  logic [3:0] m1_d1 = '0;
  logic [3:0] m2_d1 = '0, m2_d2 = '0, m2_d3 = '0;
  always @(posedge clk) begin
    m0_d1 <= bus0.bram_addr[3:0];
    m0_d2 <= m0_d1;
    m1_d1 <= bus1.bram_addr[3:0];
    m2_d1 <= bus2.bram_addr[3:0];
    m2_d2 <= m2_d1;
    m2_d3 <= m2_d2;
  end
  assign bus0.bram_read_data = m0_d2;
  assign bus1.bram_read_data = m1_d1;
  assign bus2.bram_read_data = m2_d3;

  bram_display_pal #(.XOFFSET(10), .YOFFSET(5), .RD_LATENCY(2)) dut0 (
    .clk(clk), .reset(rst_n[0]), .hcount(hc[0]), .vcount(vc[0]),
    .hsync_in(hs_i[0]), .vsync_in(vs_i[0]), .blank_in(bl_i[0]), .bram(bus0.master),
    .pal_we(pal_we[0]), .pal_waddr(pal_waddr[0]), .pal_wdata(pal_wdata[0]),
    .br_pixel(pix_o[0]), .hsync_out(hs_o[0]), .vsync_out(vs_o[0]),
    .blank_out(bl_o[0]), .in_window(win_o[0]));

  bram_display_pal #(.IMG_W(320), .IMG_H(240), .SCALE_LOG2(1), .RD_LATENCY(1)) dut1 (
    .clk(clk), .reset(rst_n[1]), .hcount(hc[1]), .vcount(vc[1]),
    .hsync_in(hs_i[1]), .vsync_in(vs_i[1]), .blank_in(bl_i[1]), .bram(bus1.master),
    .pal_we(pal_we[1]), .pal_waddr(pal_waddr[1]), .pal_wdata(pal_wdata[1]),
    .br_pixel(pix_o[1]), .hsync_out(hs_o[1]), .vsync_out(vs_o[1]),
    .blank_out(bl_o[1]), .in_window(win_o[1]));

  bram_display_pal #(.XOFFSET(800), .RD_LATENCY(3)) dut2 (
    .clk(clk), .reset(rst_n[2]), .hcount(hc[2]), .vcount(vc[2]),
    .hsync_in(hs_i[2]), .vsync_in(vs_i[2]), .blank_in(bl_i[2]), .bram(bus2.master),
    .pal_we(pal_we[2]), .pal_waddr(pal_waddr[2]), .pal_wdata(pal_wdata[2]),
    .br_pixel(pix_o[2]), .hsync_out(hs_o[2]), .vsync_out(vs_o[2]),
    .blank_out(bl_o[2]), .in_window(win_o[2]));

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    int          due;
    int          d;
    bit          is_addr;
    logic [18:0] addr;
    pixel_t      pix;
    logic        win, hs, vs, bl;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic compare(input exp_t e);
    checks++;
    if (e.is_addr) begin
      if (addr_o[e.d] !== e.addr) begin
        errors++;
        $display("FAIL %s dut%0d: bram_addr=%0d expected %0d", e.tag, e.d, addr_o[e.d], e.addr);
      end
    end else if ({pix_o[e.d], win_o[e.d], hs_o[e.d], vs_o[e.d], bl_o[e.d]}
                 !== {e.pix, e.win, e.hs, e.vs, e.bl}) begin
      errors++;
      $display("FAIL %s dut%0d: pix=%h win=%b hs=%b vs=%b blank=%b expected pix=%h win=%b hs=%b vs=%b blank=%b",
               e.tag, e.d, pix_o[e.d], win_o[e.d], hs_o[e.d], vs_o[e.d], bl_o[e.d],
               e.pix, e.win, e.hs, e.vs, e.bl);
    end
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        compare(sb[i]);
        sb.delete(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input int h, input int v,
                       input logic hs, input logic vs, input logic bl);
    hc[d]   = 11'(h);
    vc[d]   = 10'(v);
    hs_i[d] = hs;
    vs_i[d] = vs;
    bl_i[d] = bl;
  endtask

  task automatic push(input int d, input int due, input bit is_addr, input int a,
                      input pixel_t p, input logic w, input logic hs, input logic vs,
                      input logic bl, input string tag);
    exp_t e;
    e.due = due;  e.d = d;  e.is_addr = is_addr;  e.addr = 19'(a);
    e.pix = p;    e.win = w; e.hs = hs; e.vs = vs; e.bl = bl; e.tag = tag;
    sb.push_back(e);
  endtask

  // One in-reset vector: outputs must hold reset values at the next edge.
  task automatic rst_vec(input int d, input int h, input int v, input string tag);
    drive(d, h, v, 1'b1, 1'b1, 1'b0);
    push(d, cyc + 1, 1'b1, 0, '0, 1'b0, 1'b0, 1'b0, 1'b0, {tag, "_addr"});
    push(d, cyc + 1, 1'b0, 0, BORDER, 1'b0, 1'b0, 1'b0, 1'b0, {tag, "_out"});
    tick();
  endtask

  task automatic vec(input int d, input int h, input int v,
                     input logic hs, input logic vs, input logic bl,
                     input int a, input pixel_t p, input logic w, input string tag);
    drive(d, h, v, hs, vs, bl);
    push(d, cyc + 1, 1'b1, a, '0, 1'b0, 1'b0, 1'b0, 1'b0, {tag, "_addr"});
    push(d, cyc + lat(d) + 2, 1'b0, 0, p, w, hs, vs, bl, {tag, "_out"});
    tick();
  endtask

  task automatic idle(input int d, input int n);
    drive(d, 0, 1000, 1'b0, 1'b0, 1'b1);
    repeat (n) tick();
  endtask

  task automatic pal_write(input int d, input int idx, input pixel_t val);
    pal_we[d]    = 1'b1;
    pal_waddr[d] = 4'(idx);
    pal_wdata[d] = val;
    tick();
    pal_we[d] = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    for (int d = 0; d < ND; d++) begin
      rst_n[d]     = 1'b0;
      pal_we[d]    = 1'b0;
      pal_waddr[d] = '0;
      pal_wdata[d] = '0;
      drive(d, 0, 1000, 1'b0, 1'b0, 1'b1);
    end
    tick();

    // Reset held during active video.
    rst_vec(0, 100, 100, "rst_c0");
    rst_vec(0, 100, 100, "rst_c1");
    rst_vec(0, 100, 100, "rst_c2");
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    idle(0, 6);

    // Instance 0: address walk with offsets 10/5.
    vec(0,  10,   5, 1, 1, 0,    0, BORDER, 1, "a_first");
    vec(0, 649,   5, 1, 1, 0,  639, FG,     1, "a_row0_end");
    vec(0, 650,   5, 0, 1, 1,    0, BORDER, 0, "a_past_right");
    vec(0, 649,   6, 1, 0, 0, 1279, FG,     1, "a_row1_end");
    vec(0, 650,   6, 1, 0, 1,    0, BORDER, 0, "a_win_off");
    vec(0,   9,   7, 0, 0, 1,    0, BORDER, 0, "a_before_left");
    vec(0,  10,   7, 0, 1, 0, 1280, BORDER, 1, "a_row2_start");
    vec(0,  13,   7, 1, 1, 0, 1283, FG,     1, "a_row2_x3");
    for (int y = 2; y <= 478; y++) begin
      drive(0, 649, y + 5, 1'b0, 1'b0, 1'b0);
      tick();
    end
    vec(0,  10, 484, 0, 0, 0, 306560, BORDER, 1, "a_last_row");
    vec(0, 649, 484, 1, 0, 0, 307199, FG,     1, "a_last_pixel");
    vec(0,  10,   5, 0, 1, 0,      0, BORDER, 1, "a_next_frame");
    vec(0,  11,   5, 0, 1, 0,      1, FG,     1, "a_next_x1");
    vec(0, 649,   5, 0, 1, 0,    639, FG,     1, "a_row0_end_b");
    vec(0, 100,   4, 0, 0, 1,      0, BORDER, 0, "a_above_top");
    vec(0,  10,   6, 0, 0, 0,      0, BORDER, 1, "a_row_base_recover");

    // Instance 0: palette write racing a lookup of the same entry.
    vec(0, 15, 5, 0, 0, 0, 5, FG,            1, "a_pal_old");
    vec(0, 15, 5, 1, 0, 0, 5, 30'h1234567,   1, "a_pal_new");
    idle(0, 1);
    pal_write(0, 5, 30'h1234567);
    idle(0, 4);

    // Instance 1: 2x replication and RD_LATENCY=1.
    pal_write(1, 1, 30'h0ABCDEF);
    vec(1,   0, 0, 0, 1, 0,   0, BORDER,       1, "b_x0");
    vec(1,   1, 0, 0, 1, 0,   0, BORDER,       1, "b_x1");
    vec(1,   2, 0, 1, 1, 0,   1, 30'h0ABCDEF,  1, "b_x2_hs");
    vec(1,   3, 0, 0, 1, 0,   1, 30'h0ABCDEF,  1, "b_x3");
    vec(1, 639, 0, 0, 0, 0, 319, FG,           1, "b_row0a_end");
    vec(1, 640, 0, 0, 0, 1,   0, BORDER,       0, "b_right_edge");
    vec(1,   0, 1, 1, 0, 0,   0, BORDER,       1, "b_y1_shared");
    vec(1, 639, 1, 0, 0, 0, 319, FG,           1, "b_row0b_end");
    vec(1,   0, 2, 0, 0, 0, 320, BORDER,       1, "b_y2_base");
    vec(1,   3, 2, 1, 0, 0, 321, 30'h0ABCDEF,  1, "b_y2_x3");
    idle(1, 4);

    // Instance 2: reset released mid-frame, window crossing hcount 1023, RD_LATENCY=3.
    rst_vec(2, 900, 200, "c_rst");
    rst_n[2] = 1'b1;
    drive(2,  900, 200, 1'b0, 1'b0, 1'b0); tick();
    drive(2, 1439, 200, 1'b0, 1'b0, 1'b0); tick();
    drive(2,  900, 201, 1'b0, 1'b0, 1'b0); tick();
    drive(2, 1439, 201, 1'b0, 1'b0, 1'b0); tick();
    idle(2, 4);
    pal_write(2, 1, 30'h2468ACE);
    vec(2,  800, 0, 0, 1, 0,    0, BORDER,      1, "c_origin");
    vec(2,  801, 0, 1, 1, 0,    1, 30'h2468ACE, 1, "c_hs_pulse");
    vec(2,  802, 0, 0, 1, 0,    2, FG,          1, "c_x2");
    vec(2, 1439, 0, 0, 0, 0,  639, FG,          1, "c_row0_end");
    vec(2,  799, 1, 0, 0, 1,    0, BORDER,      0, "c_before_left");
    vec(2,  800, 1, 0, 0, 0,  640, BORDER,      1, "c_row1_origin");
    vec(2, 1025, 1, 1, 0, 0,  865, 30'h2468ACE, 1, "c_cross_1024");
    vec(2, 1439, 1, 0, 0, 0, 1279, FG,          1, "c_row1_end");
    vec(2, 1440, 1, 0, 0, 1,    0, BORDER,      0, "c_past_right");
    idle(2, 10);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations unchecked, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
